mem_access_stage: RTL

- Memory-access stage sitting directly upstream of the byte-addressed data memory.
- Accepts one load/store/pass-through request per handshake from the execute stage.
- Drives the data memory's address/write_data/mem_rd/mem_wr/size inputs for exactly one cycle, captures and sign/zero-extends load data, and presents a registered write-back result to the downstream stage with a valid/ready handshake.
- Checks alignment and address range before any memory strobe is issued.

---
 rtl/mem_access_stage.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues one-cycle data-memory strobes,
// checks alignment/range, extends load data and hands off a write-back.
module mem_access_stage #(
  parameter int MEM_BYTES = 1024,
  parameter int RD_W      = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_addr,
  input  logic [31:0]     in_wdata,
  input  logic            in_mem_rd,
  input  logic            in_mem_wr,
  input  logic            in_size,
  input  logic            in_unsigned,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_reg_write,
  output logic [31:0]     dm_address,
  output logic [31:0]     dm_write_data,
  output logic            dm_mem_rd,
  output logic            dm_mem_wr,
  output logic            dm_size,
  input  logic [31:0]     dm_read_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     wb_data,
  output logic [RD_W-1:0] wb_rd,
  output logic            wb_reg_write,
  output logic            wb_fault
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_e;

  state_e            state_q;
  logic [31:0]       dm_addr_q;
  logic [31:0]       dm_wdata_q;
  logic              dm_rd_q;
  logic              dm_wr_q;
  logic              dm_size_q;
  logic              req_uns_q;
  logic [31:0]       wb_data_q;
  logic [RD_W-1:0]   wb_rd_q;
  logic              wb_regw_q;
  logic              wb_fault_q;

  logic              accept;
  logic              is_mem;
  logic [32:0]       last_byte;
  logic              misalign;
  logic              fault;
  logic [7:0]        rd_byte;
  logic [31:0]       load_d;

  assign in_ready = (state_q == IDLE) ||
                    (state_q == RESP && out_ready);
  assign out_valid = (state_q == RESP);
  assign accept    = in_valid && in_ready;
  assign is_mem    = in_mem_rd || in_mem_wr;

  // 33-bit sum so addresses near 2^32 cannot wrap into range
  assign last_byte = {1'b0, in_addr} +
                     (in_size ? 33'd3 : 33'd0);
  assign misalign  = in_size && (in_addr[1:0] != 2'b00);
  assign fault     = is_mem &&
                     (misalign || last_byte >= 33'(MEM_BYTES));

  assign rd_byte = dm_read_data[7:0];

  always_comb begin
    load_d = dm_read_data;
    if (!dm_size_q) begin
      load_d = req_uns_q ? {24'b0, rd_byte}
                         : {{24{rd_byte[7]}}, rd_byte};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      dm_rd_q    <= 1'b0;
      dm_wr_q    <= 1'b0;
      dm_size_q  <= 1'b0;
      req_uns_q  <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_regw_q  <= 1'b0;
      wb_fault_q <= 1'b0;
    end else begin
      dm_rd_q <= 1'b0;
      dm_wr_q <= 1'b0;
      unique case (state_q)
        ACCESS: begin
          wb_data_q <= dm_wr_q ? 32'd0 : load_d;
          state_q   <= RESP;
        end
        IDLE, RESP: begin
          if (accept) begin
            wb_rd_q   <= in_rd;
            req_uns_q <= in_unsigned;
            if (fault) begin
              wb_data_q  <= '0;
              wb_regw_q  <= 1'b0;
              wb_fault_q <= 1'b1;
              state_q    <= RESP;
            end else if (is_mem) begin
              dm_addr_q  <= in_addr;
              dm_size_q  <= in_size;
              dm_wdata_q <= in_size ? in_wdata
                                    : {24'b0, in_wdata[7:0]};
              // a combined rd+wr request is a store only
              dm_rd_q    <= in_mem_rd && !in_mem_wr;
              dm_wr_q    <= in_mem_wr;
              wb_regw_q  <= in_reg_write && !in_mem_wr;
              wb_fault_q <= 1'b0;
              state_q    <= ACCESS;
            end else begin
              wb_data_q  <= in_addr;
              wb_regw_q  <= in_reg_write;
              wb_fault_q <= 1'b0;
              state_q    <= RESP;
            end
          end else if (state_q == RESP && out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dm_address    = dm_addr_q;
  assign dm_write_data = dm_wdata_q;
  assign dm_mem_rd     = dm_rd_q;
  assign dm_mem_wr     = dm_wr_q;
  assign dm_size       = dm_size_q;
  assign wb_data       = wb_data_q;
  assign wb_rd         = wb_rd_q;
  assign wb_reg_write  = wb_regw_q;
  assign wb_fault      = wb_fault_q;

endmodule
